// File: rtl/mix_seq_pkg.sv
// Shared types and constants for the mixing-chain valve sequencer.
package mix_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INLET,
    ST_SETTLE_I,
    ST_MIX,
    ST_SETTLE_M,
    ST_FLUSH,
    ST_DONE
  } state_t;

  localparam int DEF_SETTLE    = 2;
  localparam int DEF_FLUSH_CYC = 3;

  function automatic int cur_ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mix_chain_sequencer_next_ch.sv
// Priority encoder: lowest eligible channel at or after the search start.
module next_enabled_ch #(
  parameter int N_CH  = 3,
  parameter int IDX_W = 2
) (
  input  logic [N_CH-1:0]  mask,
  input  logic [N_CH-1:0]  dwell_nz,
  input  logic [IDX_W-1:0] cur_idx,
  input  logic             first,
  output logic [IDX_W-1:0] next_idx,
  output logic             valid
);

  // Descending scan so the lowest qualifying index is the one left standing.
  always_comb begin
    valid    = 1'b0;
    next_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask[i] && dwell_nz[i] && (first || (i > int'(cur_idx)))) begin
        valid    = 1'b1;
        next_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/mix_chain_sequencer.sv
// Valve sequencer: doses enabled inlets in order, mixes, then flushes the outlet.
module mix_chain_sequencer
  import mix_seq_pkg::*;
#(
  parameter int N_CH      = 3,
  parameter int CNT_W     = 16,
  parameter int SETTLE    = DEF_SETTLE,
  parameter int FLUSH_CYC = DEF_FLUSH_CYC
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [N_CH-1:0]             ch_mask,
  input  logic [N_CH*CNT_W-1:0]       dwell,
  input  logic [CNT_W-1:0]            mix_cycles,
  output logic [N_CH-1:0]             inlet_valve,
  output logic                        mix_valve,
  output logic                        out_valve,
  output logic                        busy,
  output logic [cur_ch_w(N_CH)-1:0]   cur_ch,
  output logic                        done,
  output logic                        aborted
);

  localparam int IDX_W = cur_ch_w(N_CH);
  localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] FLUSH_CNT  = CNT_W'(FLUSH_CYC);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        cur_ch_q, cur_ch_d;
  logic [N_CH-1:0]         inlet_valve_q, inlet_valve_d;
  logic                    mix_valve_q, mix_valve_d;
  logic                    out_valve_q, out_valve_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    aborted_q, aborted_d;

  logic [N_CH-1:0]         mask_q, nz_q;
  logic [N_CH*CNT_W-1:0]   dwell_q;
  logic [CNT_W-1:0]        mix_q;

  logic [N_CH-1:0]         nz_live, mask_sel, nz_sel;
  logic [N_CH*CNT_W-1:0]   dwell_sel;
  logic [CNT_W-1:0]        mix_sel, dwell_ld;
  logic                    idle_like, run_active, accept, last, goto_next;
  logic [IDX_W-1:0]        nxt_idx;
  logic                    nxt_valid;

  for (genvar i = 0; i < N_CH; i++) begin : g_nz
    assign nz_live[i] = |dwell[i*CNT_W +: CNT_W];
  end

  // While idle the encoder looks at the live inputs, so the first channel is
  // chosen in the same cycle the configuration is latched.
  assign idle_like  = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign run_active = !idle_like;
  assign accept     = idle_like && start && !abort;
  assign mask_sel   = idle_like ? ch_mask    : mask_q;
  assign nz_sel     = idle_like ? nz_live    : nz_q;
  assign dwell_sel  = idle_like ? dwell      : dwell_q;
  assign mix_sel    = idle_like ? mix_cycles : mix_q;
  assign last       = (cnt_q == CNT_W'(1));
  assign goto_next  = accept || ((state_q == ST_SETTLE_I) && last);
  assign dwell_ld   = dwell_sel[nxt_idx*CNT_W +: CNT_W];

  next_enabled_ch #(
    .N_CH  (N_CH),
    .IDX_W (IDX_W)
  ) u_next (
    .mask     (mask_sel),
    .dwell_nz (nz_sel),
    .cur_idx  (cur_ch_q),
    .first    (idle_like),
    .next_idx (nxt_idx),
    .valid    (nxt_valid)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q - CNT_W'(1);
    cur_ch_d  = cur_ch_q;
    aborted_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = cnt_q;
      end
      ST_INLET:    if (last) begin state_d = ST_SETTLE_I; cnt_d = SETTLE_CNT; end
      ST_SETTLE_I: ;
      ST_MIX:      if (last) begin state_d = ST_SETTLE_M; cnt_d = SETTLE_CNT; end
      ST_SETTLE_M: if (last) begin state_d = ST_FLUSH;    cnt_d = FLUSH_CNT;  end
      ST_FLUSH:    if (last) state_d = ST_DONE;
      default:     state_d = ST_IDLE;
    endcase
    if (goto_next) begin
      if (nxt_valid) begin
        state_d  = ST_INLET;
        cnt_d    = dwell_ld;
        cur_ch_d = nxt_idx;
      end else if (mix_sel != '0) begin
        state_d = ST_MIX;
        cnt_d   = mix_sel;
      end else begin
        state_d = ST_FLUSH;
        cnt_d   = FLUSH_CNT;
      end
    end
    if (abort && run_active) begin
      state_d   = ST_IDLE;
      cnt_d     = cnt_q;
      cur_ch_d  = cur_ch_q;
      aborted_d = 1'b1;
    end
    inlet_valve_d = (state_d == ST_INLET) ? (N_CH'(1) << cur_ch_d) : '0;
    mix_valve_d   = (state_d == ST_MIX);
    out_valve_d   = (state_d == ST_FLUSH);
    busy_d        = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d        = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      cur_ch_q      <= '0;
      inlet_valve_q <= '0;
      mix_valve_q   <= 1'b0;
      out_valve_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cur_ch_q      <= cur_ch_d;
      inlet_valve_q <= inlet_valve_d;
      mix_valve_q   <= mix_valve_d;
      out_valve_q   <= out_valve_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
    end
  end

  // Run configuration is captured once per accepted start.
  always_ff @(posedge clk) begin
    if (accept) begin
      mask_q  <= ch_mask;
      nz_q    <= nz_live;
      dwell_q <= dwell;
      mix_q   <= mix_cycles;
    end
  end

  assign inlet_valve = inlet_valve_q;
  assign mix_valve   = mix_valve_q;
  assign out_valve   = out_valve_q;
  assign busy        = busy_q;
  assign cur_ch      = cur_ch_q;
  assign done        = done_q;
  assign aborted     = aborted_q;

endmodule
